// File: rtl/axi_slice_pkg.sv
// Shared types and width helpers for the AXI4 register slice.
//   slice_mode_e  : per-channel build mode (bypass / half / full)
//   skid_state_e  : occupancy of a full-mode (2-entry) stage
//   *_pld_w()     : concatenated payload width of each AXI channel
package axi_slice_pkg;

    typedef enum logic [1:0] {
        SLICE_BYPASS = 2'd0,
        SLICE_HALF   = 2'd1,
        SLICE_FULL   = 2'd2
    } slice_mode_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_e;

    localparam int AXI_SIZE_W = 3;
    localparam int AXI_LEN_W  = 8;
    localparam int AXI_RESP_W = 2;

    // AW / AR payload: {id, addr, len, size}
    function automatic int addr_pld_w(input int id_w, input int addr_w);
        return id_w + addr_w + AXI_LEN_W + AXI_SIZE_W;
    endfunction

    // W payload: {data, strb, last}
    function automatic int w_pld_w(input int data_w);
        return data_w + data_w / 8 + 1;
    endfunction

    // B payload: {id, resp}
    function automatic int b_pld_w(input int id_w);
        return id_w + AXI_RESP_W;
    endfunction

    // R payload: {id, data, resp, last}
    function automatic int r_pld_w(input int id_w, input int data_w);
        return id_w + data_w + AXI_RESP_W + 1;
    endfunction

endpackage

// File: rtl/axi_chan_slice.sv
// Generic valid/ready register stage for one AXI channel.
//   clk, rst             : clock, async active-high reset
//   in_valid/in_ready    : upstream handshake, in_data payload
//   out_valid/out_ready  : downstream handshake, out_data payload
// MODE 0 = bypass (wires), 1 = half (single entry, 1 beat / 2 cycles),
// 2 = full (main + skid register, 1 beat / cycle). In half/full mode both
// in_ready and out_valid come straight from flops, so no combinational
// path crosses the stage.
module axi_chan_slice
    import axi_slice_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int MODE  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    generate
        if (MODE == SLICE_BYPASS) begin : g_bypass
            assign out_valid = in_valid;
            assign in_ready  = out_ready;
            assign out_data  = in_data;

            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;

        end else if (MODE == SLICE_HALF) begin : g_half
            logic             full_q, full_d;
            logic             ready_q, ready_d;
            logic [WIDTH-1:0] data_q, data_d;

            // ready_q mirrors ~full_q except right after reset, where it
            // stays low until the first edge.
            always_comb begin
                full_d = full_q;
                data_d = data_q;
                if (full_q) begin
                    if (out_ready) full_d = 1'b0;
                end else if (in_valid && ready_q) begin
                    full_d = 1'b1;
                    data_d = in_data;
                end
                ready_d = ~full_d;
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    full_q  <= 1'b0;
                    ready_q <= 1'b0;
                end else begin
                    full_q  <= full_d;
                    ready_q <= ready_d;
                end
            end

            // Payload is deliberately not reset.
            always_ff @(posedge clk) begin
                data_q <= data_d;
            end

            assign in_ready  = ready_q;
            assign out_valid = full_q;
            assign out_data  = data_q;

        end else if (MODE == SLICE_FULL) begin : g_full
            skid_state_e      state_q, state_d;
            logic             ready_q, ready_d;
            logic [WIDTH-1:0] main_q, main_d;
            logic [WIDTH-1:0] skid_q, skid_d;
            logic             in_xfer, out_xfer;

            assign in_xfer  = in_valid && ready_q;
            assign out_xfer = (state_q != ST_EMPTY) && out_ready;

            // main_q always holds the oldest beat; skid_q only the second
            // one, and it is only written when main_q cannot drain.
            always_comb begin
                state_d = state_q;
                main_d  = main_q;
                skid_d  = skid_q;
                case (state_q)
                    ST_EMPTY: begin
                        if (in_xfer) begin
                            state_d = ST_ONE;
                            main_d  = in_data;
                        end
                    end
                    ST_ONE: begin
                        if (in_xfer && !out_xfer) begin
                            state_d = ST_TWO;
                            skid_d  = in_data;
                        end else if (out_xfer && !in_xfer) begin
                            state_d = ST_EMPTY;
                        end else if (in_xfer && out_xfer) begin
                            main_d  = in_data;
                        end
                    end
                    ST_TWO: begin
                        // in_ready is low here, so only the drain matters.
                        if (out_xfer) begin
                            state_d = ST_ONE;
                            main_d  = skid_q;
                        end
                    end
                    default: state_d = ST_EMPTY;
                endcase
                ready_d = (state_d != ST_TWO);
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    state_q <= ST_EMPTY;
                    ready_q <= 1'b0;
                end else begin
                    state_q <= state_d;
                    ready_q <= ready_d;
                end
            end

            always_ff @(posedge clk) begin
                main_q <= main_d;
                skid_q <= skid_d;
            end

            assign in_ready  = ready_q;
            assign out_valid = (state_q != ST_EMPTY);
            assign out_data  = main_q;

        end else begin : g_illegal
            $error("axi_chan_slice: illegal MODE %0d", MODE);
        end
    endgenerate

endmodule

// File: rtl/axi_reg_slice.sv
// AXI4 register slice: one independent axi_chan_slice per channel.
//   clk, rst         : clock, async active-high reset
//   s_aw*/s_w*/s_ar* : upstream request channels (in), s_b*/s_r* responses (out)
//   m_aw*/m_w*/m_ar* : downstream request channels (out), m_b*/m_r* responses (in)
// Request channels flow s_ -> m_, response channels m_ -> s_. This level
// only packs and unpacks payloads.
module axi_reg_slice
    import axi_slice_pkg::*;
#(
    parameter int ID_W    = 16,
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 512,
    parameter int AW_MODE = 2,
    parameter int W_MODE  = 2,
    parameter int B_MODE  = 2,
    parameter int AR_MODE = 2,
    parameter int R_MODE  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    // upstream write address
    input  logic [ID_W-1:0]       s_awid,
    input  logic [ADDR_W-1:0]     s_awaddr,
    input  logic [7:0]            s_awlen,
    input  logic [2:0]            s_awsize,
    input  logic                  s_awvalid,
    output logic                  s_awready,
    // upstream write data
    input  logic [DATA_W-1:0]     s_wdata,
    input  logic [DATA_W/8-1:0]   s_wstrb,
    input  logic                  s_wlast,
    input  logic                  s_wvalid,
    output logic                  s_wready,
    // upstream write response
    output logic [ID_W-1:0]       s_bid,
    output logic [1:0]            s_bresp,
    output logic                  s_bvalid,
    input  logic                  s_bready,
    // upstream read address
    input  logic [ID_W-1:0]       s_arid,
    input  logic [ADDR_W-1:0]     s_araddr,
    input  logic [7:0]            s_arlen,
    input  logic [2:0]            s_arsize,
    input  logic                  s_arvalid,
    output logic                  s_arready,
    // upstream read data
    output logic [ID_W-1:0]       s_rid,
    output logic [DATA_W-1:0]     s_rdata,
    output logic [1:0]            s_rresp,
    output logic                  s_rlast,
    output logic                  s_rvalid,
    input  logic                  s_rready,
    // downstream write address
    output logic [ID_W-1:0]       m_awid,
    output logic [ADDR_W-1:0]     m_awaddr,
    output logic [7:0]            m_awlen,
    output logic [2:0]            m_awsize,
    output logic                  m_awvalid,
    input  logic                  m_awready,
    // downstream write data
    output logic [DATA_W-1:0]     m_wdata,
    output logic [DATA_W/8-1:0]   m_wstrb,
    output logic                  m_wlast,
    output logic                  m_wvalid,
    input  logic                  m_wready,
    // downstream write response
    input  logic [ID_W-1:0]       m_bid,
    input  logic [1:0]            m_bresp,
    input  logic                  m_bvalid,
    output logic                  m_bready,
    // downstream read address
    output logic [ID_W-1:0]       m_arid,
    output logic [ADDR_W-1:0]     m_araddr,
    output logic [7:0]            m_arlen,
    output logic [2:0]            m_arsize,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    // downstream read data
    input  logic [ID_W-1:0]       m_rid,
    input  logic [DATA_W-1:0]     m_rdata,
    input  logic [1:0]            m_rresp,
    input  logic                  m_rlast,
    input  logic                  m_rvalid,
    output logic                  m_rready
);

    localparam int AW_PW = addr_pld_w(ID_W, ADDR_W);
    localparam int W_PW  = w_pld_w(DATA_W);
    localparam int B_PW  = b_pld_w(ID_W);
    localparam int R_PW  = r_pld_w(ID_W, DATA_W);

    logic [AW_PW-1:0] aw_in, aw_out, ar_in, ar_out;
    logic [W_PW-1:0]  w_in, w_out;
    logic [B_PW-1:0]  b_in, b_out;
    logic [R_PW-1:0]  r_in, r_out;

    assign aw_in = {s_awid, s_awaddr, s_awlen, s_awsize};
    assign {m_awid, m_awaddr, m_awlen, m_awsize} = aw_out;
    assign w_in  = {s_wdata, s_wstrb, s_wlast};
    assign {m_wdata, m_wstrb, m_wlast} = w_out;
    assign b_in  = {m_bid, m_bresp};
    assign {s_bid, s_bresp} = b_out;
    assign ar_in = {s_arid, s_araddr, s_arlen, s_arsize};
    assign {m_arid, m_araddr, m_arlen, m_arsize} = ar_out;
    assign r_in  = {m_rid, m_rdata, m_rresp, m_rlast};
    assign {s_rid, s_rdata, s_rresp, s_rlast} = r_out;

    axi_chan_slice #(.WIDTH(AW_PW), .MODE(AW_MODE)) u_aw (
        .clk(clk), .rst(rst),
        .in_valid(s_awvalid), .in_ready(s_awready), .in_data(aw_in),
        .out_valid(m_awvalid), .out_ready(m_awready), .out_data(aw_out)
    );

    axi_chan_slice #(.WIDTH(W_PW), .MODE(W_MODE)) u_w (
        .clk(clk), .rst(rst),
        .in_valid(s_wvalid), .in_ready(s_wready), .in_data(w_in),
        .out_valid(m_wvalid), .out_ready(m_wready), .out_data(w_out)
    );

    axi_chan_slice #(.WIDTH(B_PW), .MODE(B_MODE)) u_b (
        .clk(clk), .rst(rst),
        .in_valid(m_bvalid), .in_ready(m_bready), .in_data(b_in),
        .out_valid(s_bvalid), .out_ready(s_bready), .out_data(b_out)
    );

    axi_chan_slice #(.WIDTH(AW_PW), .MODE(AR_MODE)) u_ar (
        .clk(clk), .rst(rst),
        .in_valid(s_arvalid), .in_ready(s_arready), .in_data(ar_in),
        .out_valid(m_arvalid), .out_ready(m_arready), .out_data(ar_out)
    );

    axi_chan_slice #(.WIDTH(R_PW), .MODE(R_MODE)) u_r (
        .clk(clk), .rst(rst),
        .in_valid(m_rvalid), .in_ready(m_rready), .in_data(r_in),
        .out_valid(s_rvalid), .out_ready(s_rready), .out_data(r_out)
    );

endmodule
